// File: rtl/retire_tracker.sv
// ---------------------------------------------------------------------------
// retire_tracker
//
// Retirement monitor for the 5-stage RISC-V core. A shadow pipe follows each
// fetched instruction through the core using the same stall and flush
// controls. When the core retires the WB instruction, a decoded commit record
// is pushed into a first-word-fallthrough trace FIFO that a consumer drains
// with a valid/ready handshake.
//
// Ports
//   clk, rst_n            core clock, asynchronous active-low reset
//   fetch_valid_i/pc_i/instr_i   fetch tap feeding tracking entry 0
//   stall_i               freeze the tracking pipe
//   flush_mask_i          bit k invalidates tracking entry k at the next edge
//   retire_i, rd_val_i    WB retirement strobe and rd value
//   trace_*_o, trace_ready_i     FIFO head record and drain handshake
//   instr_count_o         accepted retirements (wraps at 2^32)
//   overflow_o            sticky: a record was dropped on a full FIFO
//   mismatch_o            sticky: retire seen while the WB entry was invalid
//   done_o                sticky: instr_count reached MAX_INSTR
// ---------------------------------------------------------------------------
module retire_tracker #(
    parameter int STAGES     = 4,
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_INSTR  = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid_i,
    input  logic [XLEN-1:0]   fetch_pc_i,
    input  logic [31:0]       fetch_instr_i,
    input  logic              stall_i,
    input  logic [STAGES-1:0] flush_mask_i,
    input  logic              retire_i,
    input  logic [XLEN-1:0]   rd_val_i,
    output logic              trace_valid_o,
    input  logic              trace_ready_i,
    output logic [XLEN-1:0]   trace_pc_o,
    output logic [31:0]       trace_instr_o,
    output logic [2:0]        trace_type_o,
    output logic [4:0]        trace_rd_o,
    output logic [XLEN-1:0]   trace_rd_val_o,
    output logic [31:0]       instr_count_o,
    output logic              overflow_o,
    output logic              mismatch_o,
    output logic              done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_B   = 3'd3;
    localparam logic [2:0] T_U   = 3'd4;
    localparam logic [2:0] T_J   = 3'd5;
    localparam logic [2:0] T_UNK = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [2:0]      ttype;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_val;
    } rec_t;

    function automatic logic [2:0] decode_type(input logic [6:0] opcode);
        logic [2:0] t;
        case (opcode)
            7'b0110011:                         t = T_R;
            7'b0010011, 7'b0000011, 7'b1100111: t = T_I;
            7'b0100011:                         t = T_S;
            7'b1100011:                         t = T_B;
            7'b0110111, 7'b0010111:             t = T_U;
            7'b1101111:                         t = T_J;
            default:                            t = T_UNK;
        endcase
        return t;
    endfunction

    // -----------------------------------------------------------------------
    // Tracking pipe
    // -----------------------------------------------------------------------
    logic done_q, done_d;
    logic retire_acc;

    // A retire while done is set is ignored entirely.
    assign retire_acc = retire_i & ~done_q;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic            vld_q, vld_d;
        logic [XLEN-1:0] pc_q;
        logic [31:0]     instr_q;
        logic            src_vld;
        logic [XLEN-1:0] src_pc;
        logic [31:0]     src_instr;
        logic            kill;

        if (gi == 0) begin : g_src_fetch
            assign src_vld   = fetch_valid_i;
            assign src_pc    = fetch_pc_i;
            assign src_instr = fetch_instr_i;
        end else begin : g_src_prev
            assign src_vld   = g_stage[gi-1].vld_q;
            assign src_pc    = g_stage[gi-1].pc_q;
            assign src_instr = g_stage[gi-1].instr_q;
        end

        // A stalled WB entry that has just retired must not retire twice.
        if (gi == STAGES-1) begin : g_kill_wb
            assign kill = stall_i & retire_acc;
        end else begin : g_kill_none
            assign kill = 1'b0;
        end

        assign vld_d = (stall_i ? vld_q : src_vld) & ~flush_mask_i[gi] & ~kill;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                pc_q    <= '0;
                instr_q <= '0;
            end else begin
                vld_q <= vld_d;
                if (!stall_i) begin
                    pc_q    <= src_pc;
                    instr_q <= src_instr;
                end
            end
        end
    end

    logic            wb_vld;
    logic [XLEN-1:0] wb_pc;
    logic [31:0]     wb_instr;

    assign wb_vld   = g_stage[STAGES-1].vld_q;
    assign wb_pc    = g_stage[STAGES-1].pc_q;
    assign wb_instr = g_stage[STAGES-1].instr_q;

    // -----------------------------------------------------------------------
    // Commit record build
    // -----------------------------------------------------------------------
    rec_t rec;
    logic no_rd;

    always_comb begin
        rec.pc     = wb_pc;
        rec.instr  = wb_instr;
        rec.ttype  = decode_type(wb_instr[6:0]);
        // Stores, branches and x0 writes carry no architectural rd result.
        no_rd      = (rec.ttype == T_S) || (rec.ttype == T_B) || (wb_instr[11:7] == 5'd0);
        rec.rd     = no_rd ? 5'd0 : wb_instr[11:7];
        rec.rd_val = no_rd ? '0 : rd_val_i;
    end

    // -----------------------------------------------------------------------
    // Trace FIFO (first-word-fallthrough)
    // -----------------------------------------------------------------------
    rec_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic          push, push_ok, pop, full;

    assign push    = retire_acc & wb_vld;
    assign pop     = (fill_q != '0) & trace_ready_i;
    assign full    = (fill_q == DEPTH_C);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            fill_d = fill_q + (AW+1)'(1);
        end else if (pop && !push_ok) begin
            fill_d = fill_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= rec;
        end
    end

    // -----------------------------------------------------------------------
    // Count and sticky status
    // -----------------------------------------------------------------------
    logic [31:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        mismatch_q, mismatch_d;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        mismatch_d = mismatch_q;
        done_d     = done_q;
        if (retire_acc && !wb_vld) begin
            mismatch_d = 1'b1;
        end
        // Dropped records still count as retired instructions.
        if (push) begin
            count_d = count_q + 32'd1;
            if (!push_ok) begin
                overflow_d = 1'b1;
            end
            if ((MAX_INSTR != 0) && (count_d == 32'(MAX_INSTR))) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            mismatch_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: head fields read as zero whenever the FIFO is empty
    // -----------------------------------------------------------------------
    rec_t head;

    assign head           = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign trace_valid_o  = (fill_q != '0);
    assign trace_pc_o     = head.pc;
    assign trace_instr_o  = head.instr;
    assign trace_type_o   = head.ttype;
    assign trace_rd_o     = head.rd;
    assign trace_rd_val_o = head.rd_val;
    assign instr_count_o  = count_q;
    assign overflow_o     = overflow_q;
    assign mismatch_o     = mismatch_q;
    assign done_o         = done_q;

endmodule
